sprite_ram_port_arbiter: RTL and testbench
==========================================

// Module: sprite_ram_port_arbiter
// PURPOSE
// - Shares the 16-bit port B (2048 words) of the VGA sprite RAM between two requesters:
//   R0, the pixel fetcher (read-only), and R1, a read/write client (collision logic or debug).
// - Issues at most one access per clk and returns read data one cycle after the grant.
// - Sits between the sprite RAM port B and the VGA sprite pipeline; port A stays on Avalon.
// PARAMETERS
// - ADDR_W      11  word address width of RAM port B
// - DATA_W      16  data width of RAM port B
// - STARVE_MAX   8  R1 wait cycles after which R1 beats R0 for one grant (2..255)
// PORTS
// - clk             in   1       system clock; RAM port B runs on the same clk
// - reset           in   1       synchronous, active-high
// - hold            in   1       1 = issue no grants (frame blanking or freeze)
// - r0_req          in   1       pixel-fetch read request; held until r0_gnt
// - r0_addr         in   ADDR_W  R0 word address
// - r0_gnt          out  1       R0 access issued this cycle
// - r0_rvalid       out  1       r0_rdata valid; 1 cycle after r0_gnt
// - r0_rdata        out  DATA_W  R0 read data
// - r1_req          in   1       R1 request; held with its fields until r1_gnt
// - r1_wr           in   1       1 = write, 0 = read
// - r1_addr         in   ADDR_W  R1 word address
// - r1_wdata        in   DATA_W  R1 write data
// - r1_be           in   2       R1 byte enables
// - r1_gnt          out  1       R1 access issued this cycle
// - r1_rvalid       out  1       r1_rdata valid; 1 cycle after a read r1_gnt
// - r1_rdata        out  DATA_W  R1 read data
// - ram_address     out  ADDR_W  to RAM address2
// - ram_chipselect  out  1       to RAM chipselect2
// - ram_write       out  1       to RAM write2
// - ram_writedata   out  DATA_W  to RAM writedata2
// - ram_byteenable  out  2       to RAM byteenable2
// - ram_readdata    in   DATA_W  from RAM readdata2 (valid 1 clk after the address is applied)
// BEHAVIOUR
// - Reset: all gnt and rvalid outputs 0; starve_cnt 0; owner register 0;
//   ram_chipselect 0, ram_write 0. rdata outputs are don't-care while their rvalid is 0.
// - Grants are combinational from the current req, hold, and starve_cnt. At most one gnt per cycle.
// - Grant rule when hold = 0:
//   - If r1_req = 1 and starve_cnt >= STARVE_MAX, grant R1.
//   - Otherwise, if r0_req = 1, grant R0.
//   - Otherwise, if r1_req = 1, grant R1.
// - hold = 1 forces both gnt = 0 and ram_chipselect = 0. starve_cnt is frozen while hold = 1.
// - RAM drive in the grant cycle:
//   - ram_chipselect = 1 and ram_address = the granted requester's address.
//   - ram_write = r1_wr and r1_gnt. Write data and byte enables come from R1 on a write.
//   - On an R0 grant, ram_byteenable = 2'b11.
// - Read return:
//   - Registers: owner <= 1 for an R1 read, 0 otherwise; rd_pend <= (gnt & ~ram_write).
//   - Next cycle: the owner's rvalid = rd_pend, and its rdata = ram_readdata.
//   - The other requester's rvalid = 0.
//   - Latency is fixed at 1 and cannot be back-pressured.
//   - A write produces no rvalid.
// - starve_cnt update, every cycle with hold = 0:
//   - r1_gnt -> clear to 0.
//   - Else if r1_req = 1 -> increment, saturating at 255.
//   - Else -> clear to 0.
// - Back-to-back: a new grant is legal every cycle, including R0->R1, R1->R0, and a write after a read.
//   A read in cycle N still returns in N+1.
// - Same-address conflict: an R1 write followed by any read of that address in the next cycle
//   returns the new data. No bypass is required, because the accesses are sequential on one port.
// - reset mid-operation: a pending rvalid is dropped and is not asserted in the cycle after reset.
// - Protocol rule: a requester must not change its request fields while req = 1 and gnt = 0.
//   The arbiter does not check this.
// CONFIGURATION
// - SPRITE_ARB_STATS_EN defined:
//   - Adds outputs stat_r0_grants[15:0], stat_r1_grants[15:0], stat_r1_stall[15:0].
//   - All three saturate and clear on reset or on the stat_clr input (1 bit).
//   - stat_r1_stall counts cycles with r1_req = 1, r1_gnt = 0, and hold = 0.
// - SPRITE_ARB_STATS_EN undefined: these ports and counters are absent. Arbitration is identical.
// TESTING
// - Reset then idle -> all gnt and rvalid 0; ram_chipselect 0 for 10 cycles.
// - r0_req = 1, addr 0x005 (RAM preloaded with 0x5A5A) -> r0_gnt in cycle N;
//   r0_rvalid = 1 with r0_rdata 0x5A5A in N+1.
// - r0_req held high and r1_req high with STARVE_MAX = 8 -> R0 wins 8 cycles;
//   r1_gnt in the 9th cycle; R0 resumes the next cycle; pattern repeats.
// - r1 write addr 0x7FF data 0xBEEF be 2'b10, then r1 read 0x7FF -> r1_rvalid with
//   r1_rdata[15:8] = 0xBE and the low byte unchanged; no rvalid on the write.
// - hold = 1 with both req high for 5 cycles -> no gnt; starve_cnt unchanged;
//   after hold drops, R0 is granted first if starve_cnt < STARVE_MAX.
// - Read granted in cycle N and reset asserted in N+1 -> no rvalid in N+1 or N+2;
//   stats (if SPRITE_ARB_STATS_EN) read 0.

Source files
------------

// File: rtl/sprite_ram_port_arbiter_if.sv
// rtl/sprite_ram_port_arbiter_if.sv - requester, hold and RAM port B signal bundle for the sprite RAM arbiter
interface sprite_ram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    // Freeze control from the video timing
    logic              hold;

    // R0: pixel fetcher, read-only
    logic              r0_req;
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    // R1: read/write client
    logic              r1_req;
    logic              r1_wr;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic [1:0]        r1_be;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    // Sprite RAM port B
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic [1:0]        ram_byteenable;
    logic [DATA_W-1:0] ram_readdata;

    // Arbiter side
    modport slave (
        input  hold,
        input  r0_req, r0_addr,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_wr, r1_addr, r1_wdata, r1_be,
        output r1_gnt, r1_rvalid, r1_rdata,
        output ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable,
        input  ram_readdata
    );

    // Requesters and RAM side
    modport master (
        output hold,
        output r0_req, r0_addr,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_wr, r1_addr, r1_wdata, r1_be,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  ram_address, ram_chipselect, ram_write, ram_writedata, ram_byteenable,
        output ram_readdata
    );
endinterface

// File: rtl/sprite_ram_port_arbiter.sv
// rtl/sprite_ram_port_arbiter.sv - two-requester arbiter for sprite RAM port B (optional stats: SPRITE_ARB_STATS_EN)
module sprite_ram_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
`ifdef SPRITE_ARB_STATS_EN
    input  logic        i_stat_clr,
    output logic [15:0] o_stat_r0_grants,
    output logic [15:0] o_stat_r1_grants,
    output logic [15:0] o_stat_r1_stall,
`endif
    sprite_ram_port_arbiter_if.slave bus
);

    // STARVE_MAX is limited to 2..255, so it always fits the 8-bit counter
    localparam logic [7:0] L_STARVE_MAX = 8'(STARVE_MAX);

    logic [7:0] r_starve_cnt;
    logic       r_owner;     // 1: the pending read belongs to R1
    logic       r_rd_pend;   // a read was issued last cycle

    logic       w_r1_urgent;
    logic       w_r0_gnt;
    logic       w_r1_gnt;
    logic       w_any_gnt;
    logic       w_ram_write;
    logic       w_r1_read;

    // Grant decision: R1 overrides R0 once it has waited STARVE_MAX cycles, else R0 has priority
    always_comb begin
        w_r1_urgent = 1'b0;
        w_r0_gnt    = 1'b0;
        w_r1_gnt    = 1'b0;
        if (!i_reset && !bus.hold) begin
            w_r1_urgent = bus.r1_req && (r_starve_cnt >= L_STARVE_MAX);
            if (w_r1_urgent) begin
                w_r1_gnt = 1'b1;
            end else if (bus.r0_req) begin
                w_r0_gnt = 1'b1;
            end else if (bus.r1_req) begin
                w_r1_gnt = 1'b1;
            end
        end
        w_any_gnt   = w_r0_gnt || w_r1_gnt;
        w_ram_write = w_r1_gnt && bus.r1_wr;
        w_r1_read   = w_r1_gnt && !bus.r1_wr;
    end

    // Steer the granted requester onto RAM port B in the grant cycle
    always_comb begin
        bus.ram_chipselect = w_any_gnt;
        bus.ram_write      = w_ram_write;
        bus.ram_address    = w_r1_gnt ? bus.r1_addr : bus.r0_addr;
        bus.ram_writedata  = w_ram_write ? bus.r1_wdata : '0;
        bus.ram_byteenable = w_r1_gnt ? bus.r1_be : 2'b11;
    end

    // Grant strobes to the requesters
    always_comb begin
        bus.r0_gnt = w_r0_gnt;
        bus.r1_gnt = w_r1_gnt;
    end

    // Read return: RAM data goes to whoever owned last cycle's read; reset kills it at once
    always_comb begin
        bus.r0_rvalid = r_rd_pend && !r_owner && !i_reset;
        bus.r1_rvalid = r_rd_pend &&  r_owner && !i_reset;
        bus.r0_rdata  = bus.ram_readdata;
        bus.r1_rdata  = bus.ram_readdata;
    end

    // Track which requester owns the read that returns next cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_pend <= 1'b0;
            r_owner   <= 1'b0;
        end else begin
            r_rd_pend <= w_any_gnt && !w_ram_write;
            r_owner   <= w_r1_read;
        end
    end

    // Count how long R1 has been waiting; frozen while hold is high
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= 8'd0;
        end else if (!bus.hold) begin
            if (w_r1_gnt) begin
                r_starve_cnt <= 8'd0;
            end else if (bus.r1_req) begin
                if (r_starve_cnt != 8'hFF) begin
                    r_starve_cnt <= r_starve_cnt + 8'd1;
                end
            end else begin
                r_starve_cnt <= 8'd0;
            end
        end
    end

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] r_stat_r0_grants;
    logic [15:0] r_stat_r1_grants;
    logic [15:0] r_stat_r1_stall;
    logic        w_r1_stall;

    // An R1 stall is a cycle where R1 asks, is not blocked by hold, and loses
    always_comb begin
        w_r1_stall = bus.r1_req && !w_r1_gnt && !bus.hold && !i_reset;
    end

    // Saturating usage counters, cleared by reset or stat_clr
    always_ff @(posedge i_clk) begin
        if (i_reset || i_stat_clr) begin
            r_stat_r0_grants <= 16'd0;
            r_stat_r1_grants <= 16'd0;
            r_stat_r1_stall  <= 16'd0;
        end else begin
            if (w_r0_gnt && (r_stat_r0_grants != 16'hFFFF)) begin
                r_stat_r0_grants <= r_stat_r0_grants + 16'd1;
            end
            if (w_r1_gnt && (r_stat_r1_grants != 16'hFFFF)) begin
                r_stat_r1_grants <= r_stat_r1_grants + 16'd1;
            end
            if (w_r1_stall && (r_stat_r1_stall != 16'hFFFF)) begin
                r_stat_r1_stall <= r_stat_r1_stall + 16'd1;
            end
        end
    end

    // Expose the counters
    always_comb begin
        o_stat_r0_grants = r_stat_r0_grants;
        o_stat_r1_grants = r_stat_r1_grants;
        o_stat_r1_stall  = r_stat_r1_stall;
    end
`endif

endmodule

// File: tb/tb_sprite_ram_port_arbiter.sv
// tb/tb_sprite_ram_port_arbiter.sv - randomized model-checked bench for sprite_ram_port_arbiter
module tb_sprite_ram_port_arbiter;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 8;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SPRITE_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_r0_grants, stat_r1_grants, stat_r1_stall;
`endif

    sprite_ram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
`ifdef SPRITE_ARB_STATS_EN
        .i_stat_clr(stat_clr),
        .o_stat_r0_grants(stat_r0_grants),
        .o_stat_r1_grants(stat_r1_grants),
        .o_stat_r1_stall(stat_r1_stall),
`endif
        .bus(bus.slave)
    );

    function automatic logic [15:0] init_val(input int a);
        if (a == 5)     return 16'h5A5A;
        if (a == 'h7FF) return 16'h1234;
        return 16'((a * 40503) ^ 16'h3C5A);
    endfunction

    // RAM port B: synchronous, read data one clock after the address
    logic [15:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
    always @(posedge clk) begin
        if (bus.ram_chipselect) begin
            if (bus.ram_write) begin
                if (bus.ram_byteenable[0]) mem[bus.ram_address][7:0]  <= bus.ram_writedata[7:0];
                if (bus.ram_byteenable[1]) mem[bus.ram_address][15:8] <= bus.ram_writedata[15:8];
            end
            bus.ram_readdata <= mem[bus.ram_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] gold [DEPTH];
    int          m_starve = 0;
    bit          m_pend   = 0;
    bit          m_owner  = 0;
    logic [15:0] m_data   = '0;
    bit          seen_r0g = 0;
    bit          seen_r1g = 0;
    initial for (int i = 0; i < DEPTH; i++) gold[i] = init_val(i);

    // Compare DUT outputs against the model every cycle, then advance the model
    always @(negedge clk) begin
        bit e0, e1, rv0, rv1;
        e1 = !reset && !bus.hold && bus.r1_req && (m_starve >= STARVE_MAX || !bus.r0_req);
        e0 = !reset && !bus.hold && bus.r0_req && !e1;
        chk("r0_gnt", 32'(bus.r0_gnt), 32'(e0));
        chk("r1_gnt", 32'(bus.r1_gnt), 32'(e1));
        chk("ram_cs", 32'(bus.ram_chipselect), 32'(e0 || e1));
        chk("ram_write", 32'(bus.ram_write), 32'(e1 && bus.r1_wr));
        if (e0) begin
            chk("ram_addr_r0", 32'(bus.ram_address), 32'(bus.r0_addr));
            chk("ram_be_r0", 32'(bus.ram_byteenable), 32'd3);
        end
        if (e1) begin
            chk("ram_addr_r1", 32'(bus.ram_address), 32'(bus.r1_addr));
            if (bus.r1_wr) begin
                chk("ram_wdata", 32'(bus.ram_writedata), 32'(bus.r1_wdata));
                chk("ram_be_r1", 32'(bus.ram_byteenable), 32'(bus.r1_be));
            end
        end
        rv0 = !reset && m_pend && !m_owner;
        rv1 = !reset && m_pend && m_owner;
        chk("r0_rvalid", 32'(bus.r0_rvalid), 32'(rv0));
        chk("r1_rvalid", 32'(bus.r1_rvalid), 32'(rv1));
        if (rv0) chk("r0_rdata", 32'(bus.r0_rdata), 32'(m_data));
        if (rv1) chk("r1_rdata", 32'(bus.r1_rdata), 32'(m_data));

        if (reset) begin
            m_starve = 0;
            m_pend   = 0;
            m_owner  = 0;
        end else begin
            m_pend  = e0 || (e1 && !bus.r1_wr);
            m_owner = e1 && !bus.r1_wr;
            if (e0) m_data = gold[bus.r0_addr];
            else if (e1 && !bus.r1_wr) m_data = gold[bus.r1_addr];
            if (e1 && bus.r1_wr) begin
                if (bus.r1_be[0]) gold[bus.r1_addr][7:0]  = bus.r1_wdata[7:0];
                if (bus.r1_be[1]) gold[bus.r1_addr][15:8] = bus.r1_wdata[15:8];
            end
            if (!bus.hold) begin
                if (e1) m_starve = 0;
                else if (bus.r1_req) m_starve = (m_starve >= 255) ? 255 : m_starve + 1;
                else m_starve = 0;
            end
        end
        seen_r0g = bus.r0_gnt;
        seen_r1g = bus.r1_gnt;
    end

    task automatic drive_idle();
        bus.hold     = 1'b0;
        bus.r0_req   = 1'b0;
        bus.r0_addr  = '0;
        bus.r1_req   = 1'b0;
        bus.r1_wr    = 1'b0;
        bus.r1_addr  = '0;
        bus.r1_wdata = '0;
        bus.r1_be    = 2'b00;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
        return ADDR_W'($urandom);
    endfunction

    initial begin
        reset = 1'b1;
`ifdef SPRITE_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        drive_idle();
        repeat (3) next_cycle();
        reset = 1'b0;

        // Idle after reset: nothing issued, nothing returned
        repeat (10) begin
            @(negedge clk);
            chk("idle_cs", 32'(bus.ram_chipselect), 32'd0);
            chk("idle_gnt", 32'({bus.r0_gnt, bus.r1_gnt}), 32'd0);
            chk("idle_rvalid", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'd0);
        end

        // Single R0 read of the preloaded word
        next_cycle();
        bus.r0_req = 1'b1; bus.r0_addr = 11'h005;
        @(negedge clk);
        chk("r0_read_gnt", 32'(bus.r0_gnt), 32'd1);
        next_cycle();
        bus.r0_req = 1'b0;
        @(negedge clk);
        chk("r0_read_rvalid", 32'(bus.r0_rvalid), 32'd1);
        chk("r0_read_rdata", 32'(bus.r0_rdata), 32'h5A5A);

        // Starvation: 8 R0 grants then one R1 grant, twice
        next_cycle();
        bus.r0_req = 1'b1; bus.r0_addr = 11'h001;
        bus.r1_req = 1'b1; bus.r1_wr = 1'b0; bus.r1_addr = 11'h002;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk("starve_r1_gnt", 32'(bus.r1_gnt), 32'((k % 9) == 8));
            chk("starve_r0_gnt", 32'(bus.r0_gnt), 32'((k % 9) != 8));
        end
        next_cycle();
        drive_idle();

        // Byte-masked write to the top word, then read it back
        next_cycle();
        bus.r1_req = 1'b1; bus.r1_wr = 1'b1; bus.r1_addr = 11'h7FF;
        bus.r1_wdata = 16'hBEEF; bus.r1_be = 2'b10;
        @(negedge clk);
        chk("wr_gnt", 32'(bus.r1_gnt), 32'd1);
        chk("wr_ram_write", 32'(bus.ram_write), 32'd1);
        next_cycle();
        bus.r1_wr = 1'b0;
        @(negedge clk);
        chk("rd_after_wr_gnt", 32'(bus.r1_gnt), 32'd1);
        chk("wr_no_rvalid", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'd0);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("rd_after_wr_rvalid", 32'(bus.r1_rvalid), 32'd1);
        chk("rd_after_wr_rdata", 32'(bus.r1_rdata), 32'hBE34);

        // Hold blocks both requesters; R0 goes first afterwards
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            bus.hold = 1'b1;
            bus.r0_req = 1'b1; bus.r0_addr = 11'h003;
            bus.r1_req = 1'b1; bus.r1_wr = 1'b0; bus.r1_addr = 11'h004;
            @(negedge clk);
            chk("hold_gnt", 32'({bus.r0_gnt, bus.r1_gnt}), 32'd0);
            chk("hold_cs", 32'(bus.ram_chipselect), 32'd0);
        end
        next_cycle();
        bus.hold = 1'b0;
        @(negedge clk);
        chk("post_hold_r0", 32'(bus.r0_gnt), 32'd1);
        chk("post_hold_r1", 32'(bus.r1_gnt), 32'd0);
        next_cycle();
        bus.r0_req = 1'b0;
        @(negedge clk);
        chk("post_hold_r1_next", 32'(bus.r1_gnt), 32'd1);
        next_cycle();
        drive_idle();

        // Reset right after a read grant drops the return
        next_cycle();
        bus.r0_req = 1'b1; bus.r0_addr = 11'h005;
        @(negedge clk);
        chk("rst_rd_gnt", 32'(bus.r0_gnt), 32'd1);
        next_cycle();
        reset = 1'b1;
        bus.r0_req = 1'b0;
        @(negedge clk);
        chk("rst_rvalid_n1", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rvalid_n2", 32'({bus.r0_rvalid, bus.r1_rvalid}), 32'd0);
`ifdef SPRITE_ARB_STATS_EN
        chk("stat_r0_rst", 32'(stat_r0_grants), 32'd0);
        chk("stat_r1_rst", 32'(stat_r1_grants), 32'd0);
        chk("stat_stall_rst", 32'(stat_r1_stall), 32'd0);
`endif

        // Randomized traffic, requesters obey the hold-until-grant rule
        repeat (4000) begin
            next_cycle();
            reset    = ($urandom_range(0, 199) == 0);
            bus.hold = ($urandom_range(0, 9) == 0);
            if (!bus.r0_req || seen_r0g) begin
                bus.r0_req  = ($urandom_range(0, 3) != 0);
                bus.r0_addr = rnd_addr();
            end
            if (!bus.r1_req || seen_r1g) begin
                bus.r1_req   = ($urandom_range(0, 2) != 0);
                bus.r1_wr    = 1'($urandom);
                bus.r1_addr  = rnd_addr();
                bus.r1_wdata = 16'($urandom);
                bus.r1_be    = 2'($urandom);
            end
        end
        next_cycle();
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
